// File: rtl/drop_ctrl.sv
// Score 4 move controller: owns the 7x6 board, validates column requests,
// animates the falling piece row by row and commits it for the current player.
module drop_ctrl #(
    parameter int unsigned DROP_TICKS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  new_game,
    input  logic                  play_req,
    input  logic [6:0]            play,
    input  logic [3:0]            free,
    input  logic                  free_valid,
    output logic [6:0]            col_sel,
    output logic [6:0][5:0][1:0]  panel,
    output logic [1:0]            player,
    output logic                  busy,
    output logic                  fall_active,
    output logic [2:0]            fall_row,
    output logic [2:0]            fall_col,
    output logic                  move_done,
    output logic                  invalid,
    output logic                  board_full
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_DROP   = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

    localparam logic [7:0] LAST_TICK = 8'(DROP_TICKS - 1);

    state_e               state_q, state_d;
    logic [6:0]           col_sel_q, col_sel_d;
    logic [6:0][5:0][1:0] panel_q, panel_d;
    logic [1:0]           player_q, player_d;
    logic [2:0]           fall_row_q, fall_row_d;
    logic [2:0]           fall_col_q, fall_col_d;
    logic [2:0]           target_q, target_d;
    logic [7:0]           tick_q, tick_d;
    logic                 move_done_q, move_done_d;
    logic                 invalid_q, invalid_d;

    logic                 play_onehot;
    logic [2:0]           play_idx;
    logic                 free_ok;
    logic                 tick_wrap;
    logic                 at_target;

    always_comb begin
        play_idx = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (play[i]) play_idx = 3'(i);
        end
    end

    assign play_onehot = (play != 7'd0) && ((play & (play - 7'd1)) == 7'd0);
    // free is only trusted when it names a real row of the 6-row board
    assign free_ok     = free_valid && (free <= 4'd5);
    assign tick_wrap   = (tick_q == LAST_TICK);
    assign at_target   = (fall_row_q == target_q);

    // state register and all datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            col_sel_q   <= '0;
            panel_q     <= '0;
            player_q    <= 2'b01;
            fall_row_q  <= '0;
            fall_col_q  <= '0;
            target_q    <= '0;
            tick_q      <= '0;
            move_done_q <= 1'b0;
            invalid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_sel_q   <= col_sel_d;
            panel_q     <= panel_d;
            player_q    <= player_d;
            fall_row_q  <= fall_row_d;
            fall_col_q  <= fall_col_d;
            target_q    <= target_d;
            tick_q      <= tick_d;
            move_done_q <= move_done_d;
            invalid_q   <= invalid_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        if (new_game) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (play_req && play_onehot) state_d = ST_CHECK;
                ST_CHECK:  state_d = free_ok ? ST_DROP : ST_IDLE;
                ST_DROP:   if (tick_wrap && at_target) state_d = ST_COMMIT;
                ST_COMMIT: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // datapath and registered-output next values
    always_comb begin
        col_sel_d   = col_sel_q;
        panel_d     = panel_q;
        player_d    = player_q;
        fall_row_d  = fall_row_q;
        fall_col_d  = fall_col_q;
        target_d    = target_q;
        tick_d      = tick_q;
        move_done_d = 1'b0;
        invalid_d   = 1'b0;
        if (new_game) begin
            col_sel_d  = '0;
            panel_d    = '0;
            player_d   = 2'b01;
            fall_row_d = '0;
            fall_col_d = '0;
            target_d   = '0;
            tick_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (play_req) begin
                        if (play_onehot) begin
                            col_sel_d  = play;
                            fall_col_d = play_idx;
                        end else begin
                            invalid_d = 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (free_ok) begin
                        target_d   = free[2:0];
                        fall_row_d = '0;
                        tick_d     = '0;
                    end else begin
                        invalid_d = 1'b1;
                        col_sel_d = '0;
                    end
                end
                ST_DROP: begin
                    if (tick_wrap) begin
                        tick_d = '0;
                        if (!at_target) fall_row_d = fall_row_q + 3'd1;
                    end else begin
                        tick_d = tick_q + 8'd1;
                    end
                end
                ST_COMMIT: begin
                    for (int c = 0; c < 7; c++) begin
                        for (int r = 0; r < 6; r++) begin
                            if (3'(c) == fall_col_q && 3'(r) == target_q) panel_d[c][r] = player_q;
                        end
                    end
                    player_d    = (player_q == 2'b01) ? 2'b10 : 2'b01;
                    move_done_d = 1'b1;
                    col_sel_d   = '0;
                end
                default: ;
            endcase
        end
    end

    // outputs decoded from registered state
    always_comb begin
        board_full = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (panel_q[c][0] == 2'b00) board_full = 1'b0;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign fall_active = (state_q == ST_DROP);
    assign col_sel     = col_sel_q;
    assign panel       = panel_q;
    assign player      = player_q;
    assign fall_row    = fall_row_q;
    assign fall_col    = fall_col_q;
    assign move_done   = move_done_q;
    assign invalid     = invalid_q;

endmodule

// File: tb/tb_drop_ctrl.sv
// Bench for drop_ctrl: directed scenarios plus random moves, all outputs
// checked every cycle against a timeline-based model of each move.
module tb_drop_ctrl;
  localparam int DT = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 new_game = 1'b0;
  logic                 play_req = 1'b0;
  logic [6:0]           play = 7'd0;
  logic [3:0]           free;
  logic                 free_valid;
  logic [6:0]           col_sel;
  logic [6:0][5:0][1:0] panel;
  logic [1:0]           player;
  logic                 busy, fall_active, move_done, invalid, board_full;
  logic [2:0]           fall_row, fall_col;
  logic                 bad_free = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int fa_cnt = 0;
  int md_cnt = 0;
  int inv_cnt = 0;

  drop_ctrl #(.DROP_TICKS(DT)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .play_req(play_req), .play(play),
    .free(free), .free_valid(free_valid), .col_sel(col_sel), .panel(panel),
    .player(player), .busy(busy), .fall_active(fall_active), .fall_row(fall_row),
    .fall_col(fall_col), .move_done(move_done), .invalid(invalid), .board_full(board_full)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // free-row finder of the surrounding system
  always_comb begin
    free = 4'd0;
    free_valid = 1'b0;
    if (bad_free) begin
      free = 4'd6;
      free_valid = 1'b1;
    end else begin
      for (int c = 0; c < 7; c++) begin
        if (col_sel[c]) begin
          for (int r = 0; r < 6; r++) begin
            if (panel[c][r] == 2'b00) begin
              free = 4'(r);
              free_valid = 1'b1;
            end
          end
        end
      end
    end
  end

  // behavioural model: a move is a timeline measured in cycles since acceptance
  logic [1:0] m_board [7][6];
  int  m_player;
  bit  m_active;
  int  m_age, m_col, m_tgt;
  bit  e_move_done, e_invalid;

  task model_clear();
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++) m_board[c][r] = 2'b00;
    m_player = 1;
    m_active = 0;
    m_age = 0;
  endtask

  function automatic int m_free(input int c);
    int f = -1;
    for (int r = 0; r < 6; r++) if (m_board[c][r] == 2'b00) f = r;
    return f;
  endfunction

  function automatic logic m_full();
    for (int c = 0; c < 7; c++) if (m_board[c][0] == 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [83:0] m_panel();
    logic [6:0][5:0][1:0] p;
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++) p[c][r] = m_board[c][r];
    return p;
  endfunction

  initial model_clear();

  always @(posedge clk) begin
    cyc++;
    e_move_done = 0;
    e_invalid = 0;
    if (rst || new_game) begin
      model_clear();
    end else if (!m_active) begin
      if (play_req) begin
        if ($countones(play) == 1) begin
          m_active = 1;
          m_age = 0;
          for (int i = 0; i < 7; i++) if (play[i]) m_col = i;
        end else begin
          e_invalid = 1;
        end
      end
    end else begin
      m_age++;
      if (m_age == 1) begin
        m_tgt = m_free(m_col);
        if (m_tgt < 0 || bad_free) begin
          m_active = 0;
          e_invalid = 1;
        end
      end else if (m_age == (m_tgt + 1) * DT + 2) begin
        m_board[m_col][m_tgt] = 2'(m_player);
        m_player = 3 - m_player;
        e_move_done = 1;
        m_active = 0;
      end
    end
  end

  // scoreboard
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      logic fa_exp;
      fa_exp = m_active && m_age >= 1 && m_age <= (m_tgt + 1) * DT;
      chk("panel", 128'(panel), 128'(m_panel()));
      chk("player", 128'(player), 128'(m_player));
      chk("board_full", 128'(board_full), 128'(m_full()));
      chk("busy", 128'(busy), 128'(m_active));
      chk("fall_active", 128'(fall_active), 128'(fa_exp));
      chk("move_done", 128'(move_done), 128'(e_move_done));
      chk("invalid", 128'(invalid), 128'(e_invalid));
      chk("col_sel", 128'(col_sel), m_active ? (128'd1 << m_col) : 128'd0);
      if (m_active) chk("fall_col", 128'(fall_col), 128'(m_col));
      if (fa_exp) chk("fall_row", 128'(fall_row), 128'((m_age - 1) / DT));
    end
  end

  always @(negedge clk) begin
    if (fall_active === 1'b1) fa_cnt++;
    if (move_done === 1'b1) md_cnt++;
    if (invalid === 1'b1) inv_cnt++;
  end

  // driver tasks
  task automatic req(input logic [6:0] v);
    @(negedge clk);
    play_req = 1'b1;
    play = v;
    @(negedge clk);
    play_req = 1'b0;
    play = 7'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle: got busy expected idle within 300 cycles");
    end
    @(negedge clk);
  endtask

  task automatic pulse_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  task automatic wait_for_drop_row(input logic [2:0] row);
    int n = 0;
    while (!(fall_active && fall_row == row) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_row: got no DROP at row %0d expected one", row);
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_panel"}, 128'(panel), 128'd0);
    chk({tag, "_player"}, 128'(player), 128'd1);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_move_done"}, 128'(move_done), 128'd0);
  endtask

  initial begin
    int md0, inv0, c, n, kind;
    logic [5:0][1:0] exp_col;
    logic [6:0] v;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_panel", 128'(panel), 128'd0);
    chk("rst_player", 128'(player), 128'd1);
    chk("rst_col_sel", 128'(col_sel), 128'd0);
    chk("rst_fall_row", 128'(fall_row), 128'd0);
    chk("rst_fall_col", 128'(fall_col), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);

    // first move: column 0 falls to row 5 in 6*4 cycles
    fa_cnt = 0;
    md0 = md_cnt;
    req(7'b0000001);
    wait_idle();
    chk("first_drop_cycles", 128'(fa_cnt), 128'd24);
    chk("first_cell", 128'(panel[0][5]), 128'd1);
    chk("first_player", 128'(player), 128'd2);
    chk("first_move_done", 128'(md_cnt - md0), 128'd1);

    // six pieces stack in column 3, seventh is rejected
    pulse_new_game();
    for (int i = 0; i < 6; i++) begin
      req(7'b0001000);
      wait_idle();
    end
    exp_col = 12'b01_10_01_10_01_10;
    chk("col3_stack", 128'(panel[3]), 128'(exp_col));
    inv0 = inv_cnt;
    req(7'b0001000);
    wait_idle();
    chk("col3_full_invalid", 128'(inv_cnt - inv0), 128'd1);
    chk("col3_unchanged", 128'(panel[3]), 128'(exp_col));
    chk("col3_player", 128'(player), 128'd1);

    // malformed requests
    req(7'b0000000);
    chk("zero_invalid", 128'(invalid), 128'd1);
    chk("zero_busy", 128'(busy), 128'd0);
    req(7'b0000011);
    chk("multi_invalid", 128'(invalid), 128'd1);
    chk("multi_busy", 128'(busy), 128'd0);
    @(negedge clk);

    // request while busy is dropped
    pulse_new_game();
    inv0 = inv_cnt;
    req(7'b0000010);
    repeat (5) @(negedge clk);
    req(7'b0000100);
    wait_idle();
    chk("busy_col1", 128'(panel[1][5]), 128'd1);
    chk("busy_col2", 128'(panel[2]), 128'd0);
    chk("busy_no_invalid", 128'(inv_cnt - inv0), 128'd0);

    // new_game mid-DROP at row 2
    req(7'b0100000);
    wait_for_drop_row(3'd2);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    check_cleared("ng_drop");
    @(negedge clk);

    // rst during COMMIT
    req(7'b0010000);
    wait_for_drop_row(3'd5);
    n = 0;
    while (fall_active && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("commit_reached", 128'(busy && !fall_active), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cleared("rst_commit");
    chk("rst_commit_fall_row", 128'(fall_row), 128'd0);
    chk("rst_commit_col_sel", 128'(col_sel), 128'd0);

    // finder reports an out-of-range row
    inv0 = inv_cnt;
    bad_free = 1'b1;
    req(7'b1000000);
    wait_idle();
    bad_free = 1'b0;
    chk("bad_free_invalid", 128'(inv_cnt - inv0), 128'd1);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (kind == 0) begin
        v = 7'(1 << $urandom_range(0, 6)) | 7'(1 << $urandom_range(0, 6));
        if ($urandom_range(0, 1) == 0) v = 7'd0;
        req(v);
        wait_idle();
      end else if (kind == 1) begin
        req(7'(1 << $urandom_range(0, 6)));
        repeat ($urandom_range(0, 20)) @(negedge clk);
        pulse_new_game();
        wait_idle();
      end else if (kind == 2) begin
        req(7'(1 << $urandom_range(0, 6)));
        repeat ($urandom_range(0, 10)) @(negedge clk);
        req(7'($urandom));
        wait_idle();
      end else begin
        req(7'(1 << $urandom_range(0, 6)));
        wait_idle();
      end
    end

    // fill the board completely
    pulse_new_game();
    md0 = md_cnt;
    for (int k = 0; k < 42; k++) begin
      do c = $urandom_range(0, 6); while (m_free(c) < 0);
      req(7'(1 << c));
      wait_idle();
    end
    chk("fill_moves", 128'(md_cnt - md0), 128'd42);
    chk("fill_board_full", 128'(board_full), 128'd1);
    inv0 = inv_cnt;
    req(7'(1 << $urandom_range(0, 6)));
    wait_idle();
    chk("full_invalid", 128'(inv_cnt - inv0), 128'd1);
    chk("full_still_full", 128'(board_full), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/drop_ctrl.md
Name: drop_ctrl

Overview:
- Owns the 7x6 Score 4 board register. It is the writer side of the board: it commits moves into the panel that the free-row finder reads.
- Takes a column request and drives the selected column to the free-row finder. It then animates the falling piece one row at a time and commits it to the panel.
- Alternates players and reports invalid moves and a full board.
- Sits between the input/debounce logic and the display/win-check logic.

Parameters:
- DROP_TICKS, 4, clock cycles the falling piece spends on each row (valid range 1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- new_game  in  1  synchronous board clear; lower priority than rst
- play_req  in  1  single-cycle move request strobe
- play  in  7  one-hot requested column; bit i = column i
- free  in  4  free row index returned by the free-row finder for col_sel
- free_valid  in  1  high when the selected column has a free row
- col_sel  out  7  one-hot column presented to the free-row finder
- panel  out  [6:0][5:0][1:0]  board, indexed panel[col][row]; 00 empty, 01 player 1, 10 player 2
- player  out  2  code of the player to move (01 or 10)
- busy  out  1  high in any state other than IDLE
- fall_active  out  1  high during DROP
- fall_row  out  3  current row of the falling piece
- fall_col  out  3  binary index of the active column
- move_done  out  1  one-cycle pulse when a piece is committed
- invalid  out  1  one-cycle pulse when a request is rejected
- board_full  out  1  high when every row-0 cell is non-zero

Behaviour:
- Geometry: row 0 is the top and row 5 is the bottom. free is the highest-index empty row of the column. Cell code 11 never appears.
- Reset (rst=1 at a clk edge):
  - panel all 00, player=01, state IDLE.
  - col_sel=0, fall_row=0, fall_col=0, tick counter 0.
  - move_done=0, invalid=0. busy, fall_active and board_full are 0 as a consequence.
  - rst overrides every state and input.
- new_game (rst=0): same effect as reset, in any state. An in-flight drop is discarded without a commit. move_done and invalid are 0 that cycle.
- IDLE:
  - play_req with play exactly one-hot: latch col_sel=play and fall_col=index, go to CHECK.
  - play_req with play zero or multi-hot: invalid=1 for one cycle, stay in IDLE.
  - play changes without play_req are ignored.
- CHECK (exactly 1 cycle): free and free_valid are sampled, being a combinational function of panel and col_sel.
  - free_valid=1 and free<=5: target=free, fall_row=0, tick counter=0, go to DROP.
  - Otherwise: invalid=1, col_sel=0, go to IDLE.
- DROP:
  - Tick counter increments each cycle. When it reaches DROP_TICKS-1 it resets to 0, and then:
    - fall_row==target: go to COMMIT.
    - Otherwise: fall_row increments.
  - Latency from CHECK exit to COMMIT entry is (target+1)*DROP_TICKS cycles.
- COMMIT (1 cycle):
  - panel[fall_col][target] = player; player toggles 01<->10.
  - move_done=1 on the following cycle, aligned with the state returning to IDLE.
  - col_sel=0, go to IDLE.
- Busy rule: play_req while busy=1 is dropped silently, with no invalid pulse and no queueing.
- board_full is combinational from panel. A request while board_full=1 is still processed and is rejected in CHECK.
- Outputs change only on clk edges, except board_full and busy, which are decoded directly from registered state.

Test Plan:
- Reset, then play_req with play=0000001 on an empty board (finder returns free=5, valid=1), DROP_TICKS=4:
  - fall_row steps 0..5, 4 cycles each.
  - After 24 DROP cycles: panel[0][5]=01, move_done pulses once, player=10.
- Six moves into column 3: pieces land in rows 5..0 with alternating codes 01/10/01/10/01/10. A seventh request to column 3 gets free_valid=0 -> invalid pulses once, panel unchanged, player unchanged.
- play=0000000 and play=0000011 with play_req -> invalid pulse the next cycle, state stays IDLE, busy stays 0.
- play_req to column 2 during DROP of column 1 -> ignored: only column 1 commits, no invalid pulse, column 2 unchanged.
- new_game asserted mid-DROP at fall_row=2 -> next cycle: panel all 00, player=01, busy=0, no move_done. The same applies to rst mid-COMMIT.
- Fill all 42 cells via requests -> board_full=1 after the 42nd move_done. Any further request -> invalid.
